// File: rtl/risc_spm_core.sv
// risc_spm_core: parametrised multicycle stored-program core with a req/ack memory port.
// Define RISC_SPM_CARRY_EN to add the carry flag and the BRC opcode (0xB).
module risc_spm_core #(
  parameter int WORD_W = 8,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              halted,
  output logic              illegal,
  output logic [WORD_W-1:0] pc_dbg,
  output logic [WORD_W-1:0] ir_dbg
);

  localparam int NREG = 2**REG_AW;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DEC, S_OPA, S_RDD, S_WRD, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
    OP_NOT  = 4'h4, OP_RD  = 4'h5, OP_WR  = 4'h6, OP_BR  = 4'h7,
    OP_BRZ  = 4'h8, OP_OR  = 4'h9, OP_XOR = 4'hA, OP_BRC = 4'hB,
    OP_HALT = 4'hF
  } opcode_t;

  state_t            state, state_d;
  logic [WORD_W-1:0] pc, pc_d, ir, ir_d, ar, ar_d;
  logic              z, z_d, illegal_d;
  logic [WORD_W-1:0] rf [NREG];

  logic              rf_we;
  logic [WORD_W-1:0] rf_wdata;

  logic [3:0]        opcode;
  logic [REG_AW-1:0] src, dest;
  logic [WORD_W-1:0] src_val, dest_val, pc_inc;
  logic [WORD_W-1:0] alu_res;
  logic              is_alu;

`ifdef RISC_SPM_CARRY_EN
  logic              c, c_d, alu_cy;
`endif

  assign opcode   = ir[WORD_W-1 -: 4];
  assign src      = ir[2*REG_AW-1 -: REG_AW];
  assign dest     = ir[REG_AW-1:0];
  assign src_val  = rf[src];
  assign dest_val = rf[dest];
  assign pc_inc   = pc + WORD_W'(1);

  // ALU; SUB's extended top bit is the borrow (dest < src)
  always_comb begin
    alu_res = '0;
    is_alu  = 1'b1;
`ifdef RISC_SPM_CARRY_EN
    alu_cy  = 1'b0;
`endif
    case (opcode)
`ifdef RISC_SPM_CARRY_EN
      OP_ADD:  {alu_cy, alu_res} = {1'b0, dest_val} + {1'b0, src_val};
      OP_SUB:  {alu_cy, alu_res} = {1'b0, dest_val} - {1'b0, src_val};
`else
      OP_ADD:  alu_res = dest_val + src_val;
      OP_SUB:  alu_res = dest_val - src_val;
`endif
      OP_AND:  alu_res = dest_val & src_val;
      OP_NOT:  alu_res = ~src_val;
      OP_OR:   alu_res = dest_val | src_val;
      OP_XOR:  alu_res = dest_val ^ src_val;
      default: is_alu  = 1'b0;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state;
    pc_d      = pc;
    ir_d      = ir;
    ar_d      = ar;
    z_d       = z;
    illegal_d = illegal;
    rf_we     = 1'b0;
    rf_wdata  = alu_res;
`ifdef RISC_SPM_CARRY_EN
    c_d       = c;
`endif
    case (state)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: if (mem_ack) begin
        ir_d    = mem_rdata;
        pc_d    = pc_inc;
        state_d = S_DEC;
      end
      S_DEC: begin
        state_d = S_FETCH;
        if (is_alu) begin
          rf_we = 1'b1;
          z_d   = (alu_res == '0);
`ifdef RISC_SPM_CARRY_EN
          c_d   = alu_cy;
`endif
        end else begin
          case (opcode)
            OP_NOP: ;
            OP_RD, OP_WR, OP_BR: state_d = S_OPA;
            OP_BRZ: if (z) state_d = S_OPA; else pc_d = pc_inc;
`ifdef RISC_SPM_CARRY_EN
            OP_BRC: if (c) state_d = S_OPA; else pc_d = pc_inc;
`endif
            OP_HALT: state_d = S_HALT;
            default: begin
              illegal_d = 1'b1;
              state_d   = S_HALT;
            end
          endcase
        end
      end
      S_OPA: if (mem_ack) begin
        case (opcode)
          OP_RD: begin
            ar_d    = mem_rdata;
            pc_d    = pc_inc;
            state_d = S_RDD;
          end
          OP_WR: begin
            ar_d    = mem_rdata;
            pc_d    = pc_inc;
            state_d = S_WRD;
          end
          default: begin
            pc_d    = mem_rdata;
            state_d = S_FETCH;
          end
        endcase
      end
      S_RDD: if (mem_ack) begin
        rf_we    = 1'b1;
        rf_wdata = mem_rdata;
        state_d  = S_FETCH;
      end
      S_WRD:   if (mem_ack) state_d = S_FETCH;
      S_HALT:  ;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus is a pure function of state and registers so it holds steady across wait states
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_FETCH, S_OPA: begin
        mem_req  = 1'b1;
        mem_addr = pc;
      end
      S_RDD: begin
        mem_req  = 1'b1;
        mem_addr = ar;
      end
      S_WRD: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ar;
        mem_wdata = src_val;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      ar      <= '0;
      z       <= 1'b0;
      illegal <= 1'b0;
`ifdef RISC_SPM_CARRY_EN
      c       <= 1'b0;
`endif
      // NOTE: the register file is a handful of flops that must read 0 after reset, so it is reset like any register.
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      ir      <= ir_d;
      ar      <= ar_d;
      z       <= z_d;
      illegal <= illegal_d;
`ifdef RISC_SPM_CARRY_EN
      c       <= c_d;
`endif
      if (rf_we) rf[dest] <= rf_wdata;
    end
  end

  assign halted = (state == S_HALT);
  assign pc_dbg = pc;
  assign ir_dbg = ir;

endmodule

// File: tb/tb_risc_spm_core.sv
// tb_risc_spm_core: directed self-checking bench for risc_spm_core with a req/ack memory model.
module tb_risc_spm_core;

  localparam int WORD_W = 8;
  localparam int REG_AW = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_ack = 1'b0;
  logic       halted, illegal;
  logic [7:0] pc_dbg, ir_dbg;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  bit         hold_ack  = 1'b0;
  bit         stall_en  = 1'b0;
  int         wait_left = 0;
  int         n_checks  = 0;
  int         n_fails   = 0;

  risc_spm_core #(.WORD_W(WORD_W), .REG_AW(REG_AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .halted   (halted),
    .illegal  (illegal),
    .pc_dbg   (pc_dbg),
    .ir_dbg   (ir_dbg)
  );

  always #5 clk = ~clk;

  // Memory model: ack decided mid-cycle, optional random waits of 0-5 cycles per transaction
  assign mem_rdata = mem[mem_addr];

  always @(negedge clk) begin
    if (!mem_req || hold_ack) mem_ack = 1'b0;
    else if (wait_left > 0) begin
      wait_left = wait_left - 1;
      mem_ack   = 1'b0;
    end else begin
      mem_ack   = 1'b1;
      wait_left = stall_en ? int'($urandom_range(0, 5)) : 0;
    end
  end

  always @(posedge clk) if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_until_halt(input int max_cycles, output int cycles);
    cycles = 0;
    while (!halted && cycles < max_cycles) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  // RD R0,[0x20]; RD R1,[0x21]; SUB R0,R1; WR R0,[0x22]; HALT
  task automatic load_prog_a();
    clear_mem();
    mem[8'h00] = 8'h50; mem[8'h01] = 8'h20;
    mem[8'h02] = 8'h51; mem[8'h03] = 8'h21;
    mem[8'h04] = 8'h24;
    mem[8'h05] = 8'h60; mem[8'h06] = 8'h22;
    mem[8'h07] = 8'hF0;
    mem[8'h20] = 8'h05; mem[8'h21] = 8'h03; mem[8'h22] = 8'hAA;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, halted, illegal, pc_dbg, ir_dbg} !== 36'h0) begin
      n_fails++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h halted=%b illegal=%b pc=%h ir=%h, expected all 0",
               mem_req, mem_we, mem_addr, mem_wdata, halted, illegal, pc_dbg, ir_dbg);
    end
    load_prog_a();
    rst = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fails++;
      $display("FAIL idle_no_req: got mem_req=%b expected 0", mem_req);
    end
    wait_edges(1);
    n_checks++;
    if ({mem_req, mem_we, mem_addr, pc_dbg} !== {1'b1, 1'b0, 8'h00, 8'h00}) begin
      n_fails++;
      $display("FAIL first_fetch: got req=%b we=%b addr=%h pc=%h expected req=1 we=0 addr=00 pc=00",
               mem_req, mem_we, mem_addr, pc_dbg);
    end
  endtask

  task automatic test_program_a();
    int cycles;
    load_prog_a();
    do_reset();
    run_until_halt(200, cycles);
    n_checks++;
    if (cycles !== 17 || halted !== 1'b1) begin
      n_fails++;
      $display("FAIL prog_a_cycles: got %0d cycles halted=%b expected 17 cycles halted=1", cycles, halted);
    end
    n_checks++;
    if (mem[8'h22] !== 8'h02) begin
      n_fails++;
      $display("FAIL prog_a_result: got mem[22]=%h expected 02", mem[8'h22]);
    end
    n_checks++;
    if ({pc_dbg, ir_dbg, illegal, mem_req} !== {8'h08, 8'hF0, 1'b0, 1'b0}) begin
      n_fails++;
      $display("FAIL prog_a_final: got pc=%h ir=%h illegal=%b req=%b expected pc=08 ir=F0 illegal=0 req=0",
               pc_dbg, ir_dbg, illegal, mem_req);
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
  endtask

  // ADD R2,R3 of FF+01 gives 0 and sets Z; BRZ taken to 0x40; WR R2; then BRC
  task automatic test_add_brz();
    int cycles;
    clear_mem();
    mem[8'h00] = 8'h52; mem[8'h01] = 8'h30;
    mem[8'h02] = 8'h53; mem[8'h03] = 8'h31;
    mem[8'h04] = 8'h1E;
    mem[8'h05] = 8'h80; mem[8'h06] = 8'h40;
    mem[8'h07] = 8'hC0;
    mem[8'h40] = 8'h68; mem[8'h41] = 8'h32;
    mem[8'h42] = 8'hB0; mem[8'h43] = 8'h50;
    mem[8'h44] = 8'hF0;
    mem[8'h50] = 8'hF0;
    mem[8'h30] = 8'hFF; mem[8'h31] = 8'h01; mem[8'h32] = 8'hAA;
    do_reset();
    run_until_halt(200, cycles);
    n_checks++;
    if (halted !== 1'b1) begin
      n_fails++;
      $display("FAIL add_brz_halt: got halted=%b after %0d cycles expected 1", halted, cycles);
    end
    n_checks++;
    if (mem[8'h32] !== 8'h00) begin
      n_fails++;
      $display("FAIL add_wrap_result: got mem[32]=%h expected 00", mem[8'h32]);
    end
`ifdef RISC_SPM_CARRY_EN
    n_checks++;
    if ({pc_dbg, illegal} !== {8'h51, 1'b0}) begin
      n_fails++;
      $display("FAIL brc_taken: got pc=%h illegal=%b expected pc=51 illegal=0", pc_dbg, illegal);
    end
`else
    n_checks++;
    if ({pc_dbg, illegal, ir_dbg} !== {8'h43, 1'b1, 8'hB0}) begin
      n_fails++;
      $display("FAIL opcode_b_illegal: got pc=%h illegal=%b ir=%h expected pc=43 illegal=1 ir=B0",
               pc_dbg, illegal, ir_dbg);
    end
`endif
  endtask

  // Logic ops, NOT, src==dest ADD, NOP, XOR-to-zero feeding a taken BRZ
  task automatic test_alu_ops();
    int cycles;
    clear_mem();
    mem[8'h00] = 8'h50; mem[8'h01] = 8'h30;
    mem[8'h02] = 8'h51; mem[8'h03] = 8'h31;
    mem[8'h04] = 8'h92;
    mem[8'h05] = 8'hA6;
    mem[8'h06] = 8'h34;
    mem[8'h07] = 8'h47;
    mem[8'h08] = 8'h15;
    mem[8'h09] = 8'h68; mem[8'h0A] = 8'h40;
    mem[8'h0B] = 8'h60; mem[8'h0C] = 8'h41;
    mem[8'h0D] = 8'h6C; mem[8'h0E] = 8'h42;
    mem[8'h0F] = 8'h64; mem[8'h10] = 8'h43;
    mem[8'h11] = 8'h00;
    mem[8'h12] = 8'hA0;
    mem[8'h13] = 8'h80; mem[8'h14] = 8'h20;
    mem[8'h15] = 8'hC0;
    mem[8'h20] = 8'hF0;
    mem[8'h30] = 8'h5C; mem[8'h31] = 8'h3A;
    do_reset();
    run_until_halt(300, cycles);
    n_checks++;
    if ({halted, illegal, pc_dbg} !== {1'b1, 1'b0, 8'h21}) begin
      n_fails++;
      $display("FAIL alu_brz_taken: got halted=%b illegal=%b pc=%h expected halted=1 illegal=0 pc=21",
               halted, illegal, pc_dbg);
    end
    n_checks++;
    if (mem[8'h40] !== 8'h66) begin
      n_fails++;
      $display("FAIL or_xor: got mem[40]=%h expected 66", mem[8'h40]);
    end
    n_checks++;
    if (mem[8'h41] !== 8'h18) begin
      n_fails++;
      $display("FAIL and: got mem[41]=%h expected 18", mem[8'h41]);
    end
    n_checks++;
    if (mem[8'h42] !== 8'hC5) begin
      n_fails++;
      $display("FAIL not: got mem[42]=%h expected C5", mem[8'h42]);
    end
    n_checks++;
    if (mem[8'h43] !== 8'h74) begin
      n_fails++;
      $display("FAIL add_self: got mem[43]=%h expected 74", mem[8'h43]);
    end
  endtask

  task automatic test_illegal();
    int cycles;
    clear_mem();
    mem[8'h00] = 8'h70; mem[8'h01] = 8'h10;
    mem[8'h10] = 8'hC0;
    do_reset();
    run_until_halt(100, cycles);
    n_checks++;
    if ({cycles == 6, halted, illegal, pc_dbg, ir_dbg} !== {1'b1, 1'b1, 1'b1, 8'h11, 8'hC0}) begin
      n_fails++;
      $display("FAIL illegal_trap: got cycles=%0d halted=%b illegal=%b pc=%h ir=%h expected cycles=6 halted=1 illegal=1 pc=11 ir=C0",
               cycles, halted, illegal, pc_dbg, ir_dbg);
    end
    for (int i = 0; i < 10; i++) begin
      wait_edges(1);
      n_checks++;
      if ({mem_req, halted, illegal, pc_dbg} !== {1'b0, 1'b1, 1'b1, 8'h11}) begin
        n_fails++;
        $display("FAIL halt_quiet: got req=%b halted=%b illegal=%b pc=%h expected req=0 halted=1 illegal=1 pc=11",
                 mem_req, halted, illegal, pc_dbg);
      end
    end
  endtask

  task automatic test_pc_wrap();
    int cycles;
    // BR at 0xFE whose operand lives at 0xFF
    clear_mem();
    mem[8'h00] = 8'h70; mem[8'h01] = 8'hFE;
    mem[8'hFE] = 8'h70; mem[8'hFF] = 8'h60;
    mem[8'h60] = 8'hF0;
    do_reset();
    wait_edges(6);
    n_checks++;
    if ({mem_req, mem_we, mem_addr, pc_dbg} !== {1'b1, 1'b0, 8'hFF, 8'hFF}) begin
      n_fails++;
      $display("FAIL br_operand_ff: got req=%b we=%b addr=%h pc=%h expected req=1 we=0 addr=FF pc=FF",
               mem_req, mem_we, mem_addr, pc_dbg);
    end
    run_until_halt(50, cycles);
    n_checks++;
    if ({halted, pc_dbg} !== {1'b1, 8'h61}) begin
      n_fails++;
      $display("FAIL br_from_ff: got halted=%b pc=%h expected halted=1 pc=61", halted, pc_dbg);
    end
    // Untaken BRZ at 0xFE skips its operand and wraps PC to 0
    mem[8'hFE] = 8'h80;
    do_reset();
    wait_edges(5);
    n_checks++;
    if ({ir_dbg, pc_dbg, mem_req} !== {8'h80, 8'hFF, 1'b0}) begin
      n_fails++;
      $display("FAIL brz_decode: got ir=%h pc=%h req=%b expected ir=80 pc=FF req=0", ir_dbg, pc_dbg, mem_req);
    end
    wait_edges(1);
    n_checks++;
    if ({mem_req, mem_addr, pc_dbg} !== {1'b1, 8'h00, 8'h00}) begin
      n_fails++;
      $display("FAIL brz_wrap: got req=%b addr=%h pc=%h expected req=1 addr=00 pc=00", mem_req, mem_addr, pc_dbg);
    end
  endtask

  task automatic test_reset_in_stall();
    int cycles;
    load_prog_a();
    do_reset();
    wait_edges(14);
    hold_ack = 1'b1;
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'h22, 8'h02}) begin
      n_fails++;
      $display("FAIL wrd_bus: got req=%b we=%b addr=%h wdata=%h expected req=1 we=1 addr=22 wdata=02",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'h22, 8'h02}) begin
      n_fails++;
      $display("FAIL wrd_hold: got req=%b we=%b addr=%h wdata=%h expected req=1 we=1 addr=22 wdata=02",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, halted, illegal, pc_dbg, ir_dbg} !== 36'h0) begin
      n_fails++;
      $display("FAIL async_abort: got req=%b we=%b addr=%h wdata=%h halted=%b illegal=%b pc=%h ir=%h expected all 0",
               mem_req, mem_we, mem_addr, mem_wdata, halted, illegal, pc_dbg, ir_dbg);
    end
    @(negedge clk);
    hold_ack = 1'b0;
    rst      = 1'b0;
    n_checks++;
    if (mem[8'h22] !== 8'hAA) begin
      n_fails++;
      $display("FAIL aborted_write: got mem[22]=%h expected AA", mem[8'h22]);
    end
    wait_edges(1);
    n_checks++;
    if ({mem_req, mem_addr, pc_dbg} !== {1'b1, 8'h00, 8'h00}) begin
      n_fails++;
      $display("FAIL restart_pc0: got req=%b addr=%h pc=%h expected req=1 addr=00 pc=00", mem_req, mem_addr, pc_dbg);
    end
    run_until_halt(200, cycles);
    n_checks++;
    if ({halted, mem[8'h22]} !== {1'b1, 8'h02}) begin
      n_fails++;
      $display("FAIL restart_result: got halted=%b mem[22]=%h expected halted=1 mem[22]=02", halted, mem[8'h22]);
    end
  endtask

  task automatic test_stalls();
    bit         prev_wait = 1'b0;
    logic       s_we;
    logic [7:0] s_addr, s_wdata;
    int         n_waits = 0;
    int         n_diff  = 0;
    load_prog_a();
    stall_en  = 1'b1;
    wait_left = 0;
    do_reset();
    for (int cyc = 0; cyc < 2000 && !halted; cyc++) begin
      @(negedge clk);
      #1;
      if (prev_wait) begin
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, s_we, s_addr, s_wdata}) begin
          n_fails++;
          $display("FAIL stall_stable: got req=%b we=%b addr=%h wdata=%h expected req=1 we=%b addr=%h wdata=%h",
                   mem_req, mem_we, mem_addr, mem_wdata, s_we, s_addr, s_wdata);
        end
      end
      prev_wait = mem_req && !mem_ack;
      if (prev_wait) n_waits++;
      s_we    = mem_we;
      s_addr  = mem_addr;
      s_wdata = mem_wdata;
    end
    stall_en  = 1'b0;
    wait_left = 0;
    n_checks++;
    if (halted !== 1'b1 || n_waits == 0) begin
      n_fails++;
      $display("FAIL stall_run: got halted=%b wait_cycles=%0d expected halted=1 wait_cycles>0", halted, n_waits);
    end
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) n_diff++;
    n_checks++;
    if (n_diff != 0 || pc_dbg !== 8'h08) begin
      n_fails++;
      $display("FAIL stall_final: got %0d differing words pc=%h expected 0 differing words pc=08", n_diff, pc_dbg);
    end
  endtask

  initial begin
    test_reset();
    test_program_a();
    test_add_brz();
    test_alu_ops();
    test_illegal();
    test_pc_wrap();
    test_reset_in_stall();
    test_stalls();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
